jtopl_wrq: RTL and testbench
============================

Name: jtopl_wrq

Overview:
- Write queue placed directly upstream of the OPL core's CPU bus (din/addr/cs_n/wr_n).
- The host pushes {register, value} pairs at any rate.
- The block replays each pair as an address write then a data write, keeping the OPL minimum recovery times: 12 cycles after an address write, 84 cycles after a data write.
- Lets fast soft-CPUs or a VGM player drive the core without polling a busy flag.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of two, 2..256.
- AW, 4: log2(DEPTH).
- ADDR_WAIT, 12: cen cycles of recovery after an address strobe.
- DATA_WAIT, 84: cen cycles of recovery after a data strobe.

Ports:
- clk  in  1  clock, same clock as the OPL core.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cen  in  1  clock enable, same signal fed to the OPL core.
- host_we  in  1  push strobe; one entry per clk cycle while high.
- host_reg  in  8  OPL register number.
- host_data  in  8  register value.
- clr_ovf  in  1  clears the overflow flag.
- full  out  1  FIFO full.
- level  out  AW+1  number of queued entries.
- busy  out  1  FIFO non-empty or sequencer not IDLE.
- overflow  out  1  sticky; set by a push that was dropped.
- opl_din  out  8  to core din.
- opl_addr  out  1  to core addr.
- opl_cs_n  out  1  to core cs_n.
- opl_wr_n  out  1  to core wr_n.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; level=0, full=0, busy=0, overflow=0.
  - Sequencer forced to IDLE, wait counter cleared.
  - opl_cs_n=1, opl_wr_n=1, opl_din=0, opl_addr=0.
  - Reset mid-sequence abandons the pair; no strobe glitch is allowed.
- FIFO push:
  - Runs on every clk edge, independent of cen.
  - Accepted when host_we=1 and (level<DEPTH or a pop happens in the same cycle).
  - Otherwise the data is dropped and overflow is set.
  - clr_ovf clears overflow; a simultaneous drop wins, so overflow stays 1.
  - Pointers wrap modulo DEPTH. full = (level==DEPTH).
- Sequencer: advances only on clk edges with cen=1.
  - IDLE: if level>0, pop the head entry, latch reg/data, go to ADDR.
  - ADDR: opl_addr=0, opl_din=reg, cs_n=wr_n=0. Next cen: go to AWAIT, counter=ADDR_WAIT-1.
  - AWAIT: strobes high; decrement the counter each cen. At 0, go to DATA.
  - DATA: opl_addr=1, opl_din=data, cs_n=wr_n=0. Next cen: go to DWAIT, counter=DATA_WAIT-1.
  - DWAIT: strobes high; decrement each cen. At 0, go to IDLE.
- Strobe timing:
  - Each strobe is low for exactly one cen period, so it spans exactly one clk with cen=1.
  - opl_din and opl_addr are stable from strobe entry through the following AWAIT/DWAIT.
- Minimum spacing:
  - Address strobe to data strobe: 1+ADDR_WAIT cen cycles.
  - Data strobe to next address strobe: 1+DATA_WAIT cen cycles; IDLE adds one further cen.
- Latency: with an empty queue, the push at edge N is popped on the first cen edge after N; the address strobe goes low in the following cycle.
- cen=0 for long stretches freezes the sequencer and its outputs; the FIFO still accepts pushes.
- level counts entries still queued; an entry is no longer counted once it has been popped into the sequencer.
- busy = (level!=0) or (state!=IDLE).

Optional Feature:
- Macro: JTOPL_WRQ_ADDRSKIP_EN.
- Defined:
  - The block keeps last_reg, the register number of the most recent address strobe. last_reg is invalid after reset.
  - On pop, if last_reg is valid and equals the popped reg, the sequencer goes IDLE->DATA directly, skipping ADDR and AWAIT.
- Not defined: every pair issues both strobes, and no last_reg storage exists.

Test Plan:
- Reset, then push {0x20,0x01} with cen=1 always:
  - Address strobe at cycle 2 with din=0x20, addr=0.
  - Data strobe 13 cycles later with din=0x01, addr=1.
  - busy falls 85 cycles after the data strobe.
- cen pulsing 1-in-4: same sequence; all spacings scale exactly x4 in clk cycles; each strobe covers exactly one cen-high cycle.
- Push 17 entries back-to-back at DEPTH=16, cen=0:
  - full=1 after 16 entries.
  - The 17th push is dropped and overflow=1.
  - clr_ovf clears overflow.
  - Once cen is enabled, the 16 pairs emerge in order.
- Full FIFO with push coinciding with the IDLE pop edge: the push is accepted, level stays 16, overflow stays 0.
- Async rst_n low during DWAIT: strobes held high, level=0, busy=0 immediately; no strobes afterwards without new pushes.
- With JTOPL_WRQ_ADDRSKIP_EN, push {0xA0,0x10} then {0xA0,0x20}: the second pair has no address strobe; its data strobe comes 1+84+1 cen cycles after the first data strobe.

Source files
------------

// File: rtl/jtopl_wrq.sv
// jtopl_wrq: write queue in front of the OPL CPU bus.
// Buffers {register, value} pairs from the host and replays each one as an
// address strobe followed by a data strobe, respecting the OPL recovery times
// (counted in cen cycles).
// Optional build macro: JTOPL_WRQ_ADDRSKIP_EN -- skip the address strobe when
// the popped register equals the register of the last address strobe.
module jtopl_wrq #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          host_we,
  input  logic [7:0]    host_reg,
  input  logic [7:0]    host_data,
  input  logic          clr_ovf,
  output logic          full,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          overflow,
  output logic [7:0]    opl_din,
  output logic          opl_addr,
  output logic          opl_cs_n,
  output logic          opl_wr_n
);

  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] ACNT     = CW'(ADDR_WAIT - 1);
  localparam logic [CW-1:0] DCNT     = CW'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AWAIT,
    ST_DATA,
    ST_DWAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      lat_data;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;
  logic            push_ok;
  logic [7:0]      head_reg;
  logic [7:0]      head_data;
`ifdef JTOPL_WRQ_ADDRSKIP_EN
  logic [7:0]      last_reg;
  logic            last_vld;
`endif

  // Pop/push qualification; a pop in the same cycle frees room for a push
  always_comb begin
    pop       = 1'b0;
    push_ok   = 1'b0;
    head_reg  = mem[rd_ptr][15:8];
    head_data = mem[rd_ptr][7:0];
    pop       = cen && (state == ST_IDLE) && (level != '0);
    push_ok   = host_we && ((level != LVL_FULL) || pop);
  end

  assign full = (level == LVL_FULL);
  assign busy = (level != '0) || (state != ST_IDLE);

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {host_reg, host_data};
  end

  // FIFO pointers, fill level and sticky overflow (a drop beats clr_ovf)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (host_we && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)        overflow <= 1'b0;
    end
  end

  // Strobe sequencer with registered bus outputs, advancing on cen only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_data <= '0;
      opl_din  <= '0;
      opl_addr <= 1'b0;
      opl_cs_n <= 1'b1;
      opl_wr_n <= 1'b1;
`ifdef JTOPL_WRQ_ADDRSKIP_EN
      last_reg <= '0;
      last_vld <= 1'b0;
`endif
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            lat_data <= head_data;
            state    <= ST_ADDR;
            opl_din  <= head_reg;
            opl_addr <= 1'b0;
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
`ifdef JTOPL_WRQ_ADDRSKIP_EN
            last_reg <= head_reg;
            last_vld <= 1'b1;
            // Same register as the last address strobe: later assignments
            // override the address-phase entry and go straight to DATA.
            if (last_vld && (last_reg == head_reg)) begin
              state    <= ST_DATA;
              opl_din  <= head_data;
              opl_addr <= 1'b1;
            end
`endif
          end
        end
        ST_ADDR: begin
          state    <= ST_AWAIT;
          cnt      <= ACNT;
          opl_cs_n <= 1'b1;
          opl_wr_n <= 1'b1;
        end
        ST_AWAIT: begin
          if (cnt == '0) begin
            state    <= ST_DATA;
            opl_din  <= lat_data;
            opl_addr <= 1'b1;
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DATA: begin
          state    <= ST_DWAIT;
          cnt      <= DCNT;
          opl_cs_n <= 1'b1;
          opl_wr_n <= 1'b1;
        end
        ST_DWAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: begin
          state    <= ST_IDLE;
          opl_cs_n <= 1'b1;
          opl_wr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrq.sv
// tb_jtopl_wrq: self-checking bench for jtopl_wrq.
// A transaction-level model predicts, per cen edge, when each queued pair is
// popped and on which cen edges its strobes must appear; every clk cycle the
// DUT outputs are compared against it. Directed sequences check the timing
// corner cases explicitly.
module tb_jtopl_wrq;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AWAIT = 12;
  localparam int DWAIT = 84;
  localparam int A     = 1 + AWAIT;   // address strobe -> data strobe
  localparam int D     = 1 + DWAIT;   // data strobe -> sequencer idle

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_reg = '0;
  logic [7:0]  host_data = '0;
  logic        clr_ovf = 1'b0;
  logic        full;
  logic [AW:0] level;
  logic        busy;
  logic        overflow;
  logic [7:0]  opl_din;
  logic        opl_addr;
  logic        opl_cs_n;
  logic        opl_wr_n;

  jtopl_wrq #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .ADDR_WAIT (AWAIT),
    .DATA_WAIT (DWAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .host_we   (host_we),
    .host_reg  (host_reg),
    .host_data (host_data),
    .clr_ovf   (clr_ovf),
    .full      (full),
    .level     (level),
    .busy      (busy),
    .overflow  (overflow),
    .opl_din   (opl_din),
    .opl_addr  (opl_addr),
    .opl_cs_n  (opl_cs_n),
    .opl_wr_n  (opl_wr_n)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ph     = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] d;
  } pair_t;

  pair_t      mq[$];
  int         ce, addr_e, data_e, idle_e, next_pop;
  logic [7:0] m_din, m_reg, m_dat, m_lr;
  logic       m_addr, m_cs, m_ovf, m_lv;

  function automatic void mreset();
    mq.delete();
    ce = 0; addr_e = -1; data_e = -1; idle_e = 0; next_pop = 0;
    m_din = '0; m_addr = 1'b0; m_cs = 1'b1; m_ovf = 1'b0;
    m_reg = '0; m_dat = '0; m_lr = '0; m_lv = 1'b0;
  endfunction

  function automatic void model_edge();
    pair_t it;
    bit    skip;
    bit    drop;
    if (!rst_n) begin
      mreset();
      return;
    end
    if (cen) begin
      ce++;
      if (ce >= next_pop && mq.size() > 0) begin
        it   = mq.pop_front();
        skip = 1'b0;
`ifdef JTOPL_WRQ_ADDRSKIP_EN
        skip = m_lv && (m_lr == it.r);
`endif
        m_reg = it.r;
        m_dat = it.d;
        if (skip) begin
          addr_e = -1;
          data_e = ce;
        end else begin
          addr_e = ce;
          data_e = ce + A;
          m_lr   = it.r;
          m_lv   = 1'b1;
        end
        idle_e   = data_e + D;
        next_pop = idle_e + 1;
      end
      m_cs = 1'b1;
      if (ce == addr_e) begin m_cs = 1'b0; m_din = m_reg; m_addr = 1'b0; end
      if (ce == data_e) begin m_cs = 1'b0; m_din = m_dat; m_addr = 1'b1; end
    end
    drop = 1'b0;
    if (host_we) begin
      if (mq.size() < DEPTH) begin
        it.r = host_reg;
        it.d = host_data;
        mq.push_back(it);
      end else drop = 1'b1;
    end
    if (drop)         m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endfunction

  task automatic check_all();
    chk("level",    level,    mq.size());
    chk("full",     full,     int'(mq.size() == DEPTH));
    chk("busy",     busy,     int'((mq.size() != 0) || (ce < idle_e)));
    chk("overflow", overflow, m_ovf);
    chk("cs_n",     opl_cs_n, m_cs);
    chk("wr_n",     opl_wr_n, m_cs);
    chk("din",      opl_din,  m_din);
    chk("addr",     opl_addr, m_addr);
  endtask

  // ---------------- strobe event recorder ----------------
  int         ev_fall[$];
  int         ev_rise[$];
  logic [7:0] ev_din[$];
  logic       ev_addr[$];
  int         busy_fall = -1;
  logic       prev_cs = 1'b1;
  logic       prev_busy = 1'b0;

  function automatic void record();
    if (prev_cs && !opl_cs_n) begin
      ev_fall.push_back(cyc);
      ev_din.push_back(opl_din);
      ev_addr.push_back(opl_addr);
    end
    if (!prev_cs && opl_cs_n) ev_rise.push_back(cyc);
    if (prev_busy && !busy) busy_fall = cyc;
    prev_cs   = opl_cs_n;
    prev_busy = busy;
  endfunction

  function automatic void clear_ev();
    ev_fall.delete(); ev_rise.delete(); ev_din.delete(); ev_addr.delete();
    busy_fall = -1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all();
    record();
  endtask

  // per: 0 = cen held low, 1 = cen always high, N = one cen cycle in N
  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      if (per == 0)      cen = 1'b0;
      else if (per == 1) cen = 1'b1;
      else               cen = ((ph % per) == per - 1);
      ph++;
      step();
    end
  endtask

  task automatic wait_idle(input int maxc, input int per);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      run(1, per);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    host_we = 1'b0; clr_ovf = 1'b0; cen = 1'b0;
    rst_n = 1'b0;
    mreset();
    #1;
    check_all();
    prev_cs = 1'b1; prev_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push1(input logic [7:0] r, input logic [7:0] d, input logic c);
    host_we = 1'b1; host_reg = r; host_data = d; cen = c;
    step();
    host_we = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       we;
    logic [7:0] r;
    logic [7:0] d;
    logic       clr;
    int         lvl;
    logic       fl;
    logic       ov;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int p;
    int lat;
    int pct;
    int cmode;

    for (int i = 0; i < 17; i++) begin
      tbl[i].we  = 1'b1;
      tbl[i].r   = 8'(8'h40 + i);
      tbl[i].d   = 8'(i * 3);
      tbl[i].clr = 1'b0;
      tbl[i].lvl = (i < 16) ? i + 1 : 16;
      tbl[i].fl  = (i >= 15);
      tbl[i].ov  = (i == 16);
    end
    tbl[17] = '{we: 1'b0, r: 8'h00, d: 8'h00, clr: 1'b1, lvl: 16, fl: 1'b1, ov: 1'b0};
    tbl[18] = '{we: 1'b1, r: 8'h77, d: 8'h77, clr: 1'b1, lvl: 16, fl: 1'b1, ov: 1'b1};
    tbl[19] = '{we: 1'b0, r: 8'h00, d: 8'h00, clr: 1'b1, lvl: 16, fl: 1'b1, ov: 1'b0};

    mreset();
    #1;
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_cs_n", opl_cs_n, 1);

    // Sequence 1: single pair, cen always high
    clear_ev();
    push1(8'h20, 8'h01, 1'b1);
    p = cyc;
    wait_idle(400, 1);
    chk("s1_nevents", ev_fall.size(), 2);
    if (ev_fall.size() == 2 && ev_rise.size() == 2) begin
      chk("s1_addr_lat",   ev_fall[0] - p, 1);
      chk("s1_addr_din",   ev_din[0], 8'h20);
      chk("s1_addr_sel",   ev_addr[0], 0);
      chk("s1_addr_width", ev_rise[0] - ev_fall[0], 1);
      chk("s1_a2d",        ev_fall[1] - ev_fall[0], A);
      chk("s1_data_din",   ev_din[1], 8'h01);
      chk("s1_data_sel",   ev_addr[1], 1);
      chk("s1_data_width", ev_rise[1] - ev_fall[1], 1);
      chk("s1_busy_fall",  busy_fall - ev_fall[1], D);
    end

    // Sequence 2: cen one in four, every spacing scales x4
    do_reset();
    clear_ev();
    ph = 0;
    push1(8'h20, 8'h01, 1'b0);
    p = cyc;
    wait_idle(2000, 4);
    chk("s2_nevents", ev_fall.size(), 2);
    if (ev_fall.size() == 2 && ev_rise.size() == 2) begin
      lat = ev_fall[0] - p;
      chk("s2_addr_lat_in_range", int'(lat >= 1 && lat <= 4), 1);
      chk("s2_addr_width", ev_rise[0] - ev_fall[0], 4);
      chk("s2_a2d",        ev_fall[1] - ev_fall[0], 4 * A);
      chk("s2_data_width", ev_rise[1] - ev_fall[1], 4);
      chk("s2_busy_fall",  busy_fall - ev_fall[1], 4 * D);
    end

    // Sequence 3: fill to full with cen low, overflow, clr_ovf
    do_reset();
    for (int i = 0; i < 20; i++) begin
      host_we = tbl[i].we; host_reg = tbl[i].r; host_data = tbl[i].d;
      clr_ovf = tbl[i].clr; cen = 1'b0;
      step();
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_full", full, tbl[i].fl);
      chk("tbl_overflow", overflow, tbl[i].ov);
    end
    host_we = 1'b0; clr_ovf = 1'b0;
    // push on the very edge that pops the head of a full FIFO
    clear_ev();
    push1(8'h55, 8'h66, 1'b1);
    chk("coinc_level", level, 16);
    chk("coinc_overflow", overflow, 0);
    chk("coinc_full", full, 1);
    wait_idle(4000, 1);
    chk("s3_nevents", ev_fall.size(), 34);
    if (ev_fall.size() == 34) begin
      for (int i = 0; i < 16; i++) begin
        chk("s3_order_reg",  ev_din[2*i],   8'(8'h40 + i));
        chk("s3_order_data", ev_din[2*i+1], 8'(i * 3));
      end
      chk("s3_last_reg",  ev_din[32], 8'h55);
      chk("s3_last_data", ev_din[33], 8'h66);
    end

    // Sequence 4: asynchronous reset while in the data recovery wait
    do_reset();
    push1(8'h11, 8'h22, 1'b0);
    push1(8'h33, 8'h44, 1'b0);
    push1(8'h55, 8'h66, 1'b0);
    run(30, 1);
    rst_n = 1'b0;
    mreset();
    #1;
    chk("arst_cs_n", opl_cs_n, 1);
    chk("arst_wr_n", opl_wr_n, 1);
    chk("arst_level", level, 0);
    chk("arst_busy", busy, 0);
    check_all();
    prev_cs = 1'b1; prev_busy = 1'b0;
    run(2, 1);
    rst_n = 1'b1;
    clear_ev();
    run(300, 1);
    chk("arst_no_strobes", ev_fall.size(), 0);

    // Sequence 5: two pairs on the same register
    do_reset();
    clear_ev();
    push1(8'hA0, 8'h10, 1'b1);
    push1(8'hA0, 8'h20, 1'b1);
    wait_idle(600, 1);
`ifdef JTOPL_WRQ_ADDRSKIP_EN
    chk("s5_nevents", ev_fall.size(), 3);
    if (ev_fall.size() == 3) begin
      chk("s5_d2d",     ev_fall[2] - ev_fall[1], 1 + D);
      chk("s5_data2",   ev_din[2], 8'h20);
      chk("s5_sel2",    ev_addr[2], 1);
    end
`else
    chk("s5_nevents", ev_fall.size(), 4);
    if (ev_fall.size() == 4) begin
      chk("s5_a2a",     ev_fall[2] - ev_fall[0], A + D + 1);
      chk("s5_addr2",   ev_din[2], 8'hA0);
      chk("s5_data2",   ev_din[3], 8'h20);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int phs = 0; phs < 8; phs++) begin
      case (phs % 4)
        0:       pct = 3;
        1:       pct = 40;
        2:       pct = 95;
        default: pct = 12;
      endcase
      cmode = phs % 3;
      if (phs == 5) do_reset();
      for (int k = 0; k < 600; k++) begin
        if (cmode == 0)      cen = 1'b1;
        else if (cmode == 1) cen = ($urandom_range(0, 3) != 0);
        else                 cen = ($urandom_range(0, 7) == 0);
        host_we   = ($urandom_range(0, 99) < pct);
        host_reg  = (phs[0]) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2));
        host_data = 8'($urandom_range(0, 255));
        clr_ovf   = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    host_we = 1'b0; clr_ovf = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
